clk_div_ctrl: RTL and testbench
===============================

# clk_div_ctrl

Programmable clock-divider controller that generates a divided clock from `clk_in` with runtime-configurable half-period and optional burst length. It sequences start, stop and ratio changes so `clk_out` never glitches or emits a runt phase. A valid/ready configuration port lets a host change the ratio while the output is running. It replaces the fixed divide-by-2 flop wherever a test channel needs a selectable or gated clock.

## Interface
- `CNT_W`, 8: width of half-period register and counter.
- `BURST_W`, 16: width of burst-length register and counter.

- `clk_in`  in  1  sole clock; all logic on its rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `cfg_valid`  in  1  host presents a new configuration.
- `cfg_ready`  out  1  controller can accept a configuration; transfer occurs when both are high.
- `cfg_div`  in  CNT_W  half-period in `clk_in` cycles; 0 is treated as 1.
- `cfg_burst`  in  BURST_W  number of full output periods; 0 means continuous.
- `start`  in  1  single-cycle request to begin output.
- `stop`  in  1  single-cycle request to end output at the next period boundary.
- `clk_out`  out  1  registered divided clock.
- `rise_pulse`  out  1  high for one cycle when `clk_out` goes 0→1.
- `fall_pulse`  out  1  high for one cycle when `clk_out` goes 1→0.
- `busy`  out  1  state is not IDLE.
- `done`  out  1  one-cycle pulse when the controller returns to IDLE.

## Operation
- States:
  - **IDLE**: `clk_out` = 0.
  - **RUN**: normal operation.
  - **STOPPING**: RUN with a stop pending.
- Active registers `div_q` and `burst_q` reset to 1 and 0 (reset ratio is divide-by-2, continuous).
- Shadow registers `div_sh` and `burst_sh` are guarded by the `sh_pend` flag.
- **Configuration**
  - `cfg_ready` = !`sh_pend`.
  - A transfer in IDLE writes the active registers directly.
  - A transfer in RUN or STOPPING writes the shadow registers and sets `sh_pend`.
  - The shadow is copied to the active registers at the next period boundary, and `sh_pend` clears there.
- **Start** (IDLE only)
  - Half counter clears to 0.
  - `clk_out` is set to 1 and `rise_pulse` asserts.
  - Remaining-period counter `rem` loads `burst_q`.
  - State goes to RUN.
  - `start` is ignored outside IDLE.
- **Phase timing**
  - The half counter increments every cycle.
  - When it reaches `max(div_q,1)-1`, the counter clears and `clk_out` toggles.
  - Output period is therefore 2·div cycles at 50% duty.
- **Period boundary**
  - This is the cycle in which a low phase completes.
  - If `rem`==1 or the state is STOPPING: go to IDLE, keep `clk_out` 0 and pulse `done`.
  - Otherwise: `clk_out` rises, `rem` decrements (only when nonzero) and any pending shadow is applied.
- **Stop**
  - In RUN, `stop` moves the state to STOPPING.
  - In IDLE or STOPPING, `stop` is ignored.
  - `start` and `stop` together in IDLE: stop wins, so the controller stays IDLE.
- Output is never truncated: every high phase and every low phase lasts exactly the `div` value active when that period began.

## Timing
- **Reset values**: `clk_out`=0, `rise_pulse`=0, `fall_pulse`=0, `busy`=0, `done`=0, `cfg_ready`=1, state IDLE.
- **Reset mid-operation** forces all outputs to these values immediately (asynchronous). There is no drain.
- **Start latency**: `start` sampled at edge k gives `clk_out`=1 and `busy`=1 after edge k.
- **Pulses**: `rise_pulse` and `fall_pulse` coincide with the first cycle of the new `clk_out` level.
- **Stop / burst end**:
  - `done` and `busy`=0 appear in the cycle after the final low phase's last cycle.
  - `clk_out` stays 0 throughout.
- **cfg handshake**:
  - After a transfer in RUN, `cfg_ready` drops on the next edge.
  - `cfg_ready` rises on the edge that applies the shadow.
- **Simultaneous transfer and boundary**: the existing shadow is applied first. The new configuration lands in the shadow and is applied at the following boundary.
- **Wrap-around**: `rem` never wraps, because it does not decrement when 0.

## Structure
- Package `clk_div_pkg` holds:
  - enum `clk_div_state_e` {IDLE, RUN, STOPPING};
  - default width localparams;
  - the constant `DIV_RESET` = 1.
- Sub-module `half_period_counter` has inputs `clk_in`, `rst_n`, `clr`, `en`, `limit`, and output `wrap`. It counts to `limit-1` and treats a `limit` of 0 as 1.
- All other logic (FSM, shadow, burst counter, outputs) lives in `clk_div_ctrl`.

## Test plan
- **Reset default**: reset, then `start` → `clk_out` period 2 cycles, continuous. `stop` → `done` after the current low phase.
- **Burst**: `cfg_div`=3, `cfg_burst`=4 in IDLE, then `start` → exactly 4 periods of 3 high / 3 low, 4 `rise_pulse`, one `done`. Total 24 cycles from `start` to `busy`=0.
- **On-the-fly change**: running with `div`=5, transfer `cfg_div`=2 mid high phase → current period stays 5/5. The next period is 2/2. `cfg_ready` is low between the transfer and the boundary.
- **Stop collision**: `start` and `stop` asserted together in IDLE → no `clk_out` edge and no `done`. `stop` during a low phase → `clk_out` stays 0, and `done` arrives at the end of that low phase.
- **Zero divide**: `cfg_div`=0 → output period 2, the same as `div`=1.
- **Async reset mid-run**: `rst_n` dropped while `clk_out`=1 → `clk_out`, `busy` and `sh_pend` clear without waiting for a clock edge. After release the controller is IDLE with `div_q`=1.

Source files
------------

// File: rtl/clk_div_pkg.sv
// clk_div_pkg: shared types and constants for the programmable clock divider.
//   clk_div_state_e : controller state (IDLE, RUN, STOPPING)
//   CNT_W_DEF       : default half-period register/counter width
//   BURST_W_DEF     : default burst register/counter width
//   DIV_RESET       : half-period loaded at reset (divide-by-2 output)
package clk_div_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RUN      = 2'd1,
        STOPPING = 2'd2
    } clk_div_state_e;

    localparam int CNT_W_DEF   = 8;
    localparam int BURST_W_DEF = 16;
    localparam int DIV_RESET   = 1;

endpackage

// File: rtl/half_period_counter.sv
// half_period_counter: free-running phase counter for the clock divider.
//   clk_in : clock
//   rst_n  : asynchronous active-low reset
//   clr    : force the count back to 0 (has priority over en)
//   en     : advance the count this cycle
//   limit  : phase length in cycles; 0 behaves as 1
//   wrap   : high in the last cycle of a phase (count == limit-1 while enabled)
import clk_div_pkg::*;

module half_period_counter #(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk_in,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    input  logic [CNT_W-1:0] limit,
    output logic             wrap
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] last;

    // A limit of 0 collapses onto 1 so the phase is never empty.
    assign last = (limit == '0) ? '0 : (limit - CNT_W'(1));
    assign wrap = en && (cnt_q == last);

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = wrap ? '0 : (cnt_q + CNT_W'(1));
        end
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/clk_div_ctrl.sv
// clk_div_ctrl: glitch-free programmable clock divider controller.
//   clk_in     : sole clock           rst_n      : async active-low reset
//   cfg_valid  : host offers config   cfg_ready  : config can be accepted
//   cfg_div    : half-period (0 -> 1) cfg_burst  : periods per burst (0 = continuous)
//   start      : begin output (IDLE)  stop       : end at next period boundary
//   clk_out    : divided clock        rise_pulse / fall_pulse : clk_out edge strobes
//   busy       : not IDLE             done       : one-cycle pulse on return to IDLE
import clk_div_pkg::*;

module clk_div_ctrl #(
    parameter int CNT_W   = CNT_W_DEF,
    parameter int BURST_W = BURST_W_DEF
) (
    input  logic               clk_in,
    input  logic               rst_n,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [CNT_W-1:0]   cfg_div,
    input  logic [BURST_W-1:0] cfg_burst,
    input  logic               start,
    input  logic               stop,
    output logic               clk_out,
    output logic               rise_pulse,
    output logic               fall_pulse,
    output logic               busy,
    output logic               done
);

    clk_div_state_e     state_q, state_d;
    logic               clk_q, clk_d;
    logic               rise_q, rise_d;
    logic               fall_q, fall_d;
    logic               done_q, done_d;
    logic [CNT_W-1:0]   div_q, div_d;
    logic [BURST_W-1:0] burst_q, burst_d;
    logic [CNT_W-1:0]   div_sh_q, div_sh_d;
    logic [BURST_W-1:0] burst_sh_q, burst_sh_d;
    logic               sh_pend_q, sh_pend_d;
    logic [BURST_W-1:0] rem_q, rem_d;

    logic               xfer;
    logic               cnt_clr;
    logic               cnt_en;
    logic               wrap;

    assign xfer   = cfg_valid && !sh_pend_q;
    assign cnt_en = (state_q != IDLE);

    half_period_counter #(
        .CNT_W (CNT_W)
    ) u_half (
        .clk_in (clk_in),
        .rst_n  (rst_n),
        .clr    (cnt_clr),
        .en     (cnt_en),
        .limit  (div_q),
        .wrap   (wrap)
    );

    always_comb begin
        state_d    = state_q;
        clk_d      = clk_q;
        done_d     = 1'b0;
        div_d      = div_q;
        burst_d    = burst_q;
        div_sh_d   = div_sh_q;
        burst_sh_d = burst_sh_q;
        sh_pend_d  = sh_pend_q;
        rem_d      = rem_q;
        cnt_clr    = 1'b0;

        case (state_q)
            IDLE: begin
                if (xfer) begin
                    div_d   = cfg_div;
                    burst_d = cfg_burst;
                end
                // stop alongside start cancels the start
                if (start && !stop) begin
                    cnt_clr = 1'b1;
                    clk_d   = 1'b1;
                    rem_d   = burst_q;
                    state_d = RUN;
                end
            end
            default: begin
                if ((state_q == RUN) && stop) begin
                    state_d = STOPPING;
                end
                if (wrap) begin
                    if (clk_q) begin
                        clk_d = 1'b0;
                    end else begin
                        // Period boundary: the low phase has just completed.
                        if (sh_pend_q) begin
                            div_d     = div_sh_q;
                            burst_d   = burst_sh_q;
                            sh_pend_d = 1'b0;
                        end
                        if ((rem_q == BURST_W'(1)) || (state_q == STOPPING)) begin
                            state_d = IDLE;
                            done_d  = 1'b1;
                        end else begin
                            clk_d = 1'b1;
                            if (rem_q != '0) begin
                                rem_d = rem_q - BURST_W'(1);
                            end
                        end
                    end
                end
                // A transfer on the boundary cycle refills the shadow after
                // the old contents were applied above.
                if (xfer) begin
                    div_sh_d   = cfg_div;
                    burst_sh_d = cfg_burst;
                    sh_pend_d  = 1'b1;
                end
            end
        endcase

        rise_d = clk_d && !clk_q;
        fall_d = !clk_d && clk_q;
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            clk_q      <= 1'b0;
            rise_q     <= 1'b0;
            fall_q     <= 1'b0;
            done_q     <= 1'b0;
            div_q      <= CNT_W'(DIV_RESET);
            burst_q    <= '0;
            div_sh_q   <= '0;
            burst_sh_q <= '0;
            sh_pend_q  <= 1'b0;
            rem_q      <= '0;
        end else begin
            state_q    <= state_d;
            clk_q      <= clk_d;
            rise_q     <= rise_d;
            fall_q     <= fall_d;
            done_q     <= done_d;
            div_q      <= div_d;
            burst_q    <= burst_d;
            div_sh_q   <= div_sh_d;
            burst_sh_q <= burst_sh_d;
            sh_pend_q  <= sh_pend_d;
            rem_q      <= rem_d;
        end
    end

    assign clk_out    = clk_q;
    assign rise_pulse = rise_q;
    assign fall_pulse = fall_q;
    assign done       = done_q;
    assign busy       = (state_q != IDLE);
    assign cfg_ready  = !sh_pend_q;

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Testbench for clk_div_ctrl: directed steps with an expected-output queue.
// Each queued entry is {clk_out, rise_pulse, fall_pulse, busy, done, cfg_ready}
// for one clk_in cycle, sampled 1 time unit after the rising edge.
module tb_clk_div_ctrl;

    localparam int CNT_W   = 8;
    localparam int BURST_W = 16;

    logic               clk_in;
    logic               rst_n;
    logic               cfg_valid;
    logic               cfg_ready;
    logic [CNT_W-1:0]   cfg_div;
    logic [BURST_W-1:0] cfg_burst;
    logic               start;
    logic               stop;
    logic               clk_out;
    logic               rise_pulse;
    logic               fall_pulse;
    logic               busy;
    logic               done;

    clk_div_ctrl #(
        .CNT_W   (CNT_W),
        .BURST_W (BURST_W)
    ) dut (
        .clk_in     (clk_in),
        .rst_n      (rst_n),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_div    (cfg_div),
        .cfg_burst  (cfg_burst),
        .start      (start),
        .stop       (stop),
        .clk_out    (clk_out),
        .rise_pulse (rise_pulse),
        .fall_pulse (fall_pulse),
        .busy       (busy),
        .done       (done)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    logic [5:0] sb[$];
    int         n_cmp;
    int         n_bad;
    int         n_rise;
    int         n_done;
    int         cyc;
    string      cur_tag;

    function automatic logic [5:0] obs_vec();
        return {clk_out, rise_pulse, fall_pulse, busy, done, cfg_ready};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clk_in cycle and compare against the next queued entry.
    task automatic tick();
        logic [5:0] exp;
        logic [5:0] obs;
        @(posedge clk_in);
        #1;
        cyc++;
        obs = obs_vec();
        if (rise_pulse === 1'b1) n_rise++;
        if (done === 1'b1) n_done++;
        if (sb.size() > 0) begin
            exp = sb.pop_front();
            n_cmp++;
            assert (obs === exp) else begin
                n_bad++;
                $error("FAIL %s cycle %0d: observed %b expected %b (clk,rise,fall,busy,done,ready)",
                       cur_tag, cyc, obs, exp);
            end
        end
    endtask

    task automatic drain();
        while (sb.size() > 0) tick();
    endtask

    task automatic exp_idle(input int n);
        for (int i = 0; i < n; i++) sb.push_back(6'b000001);
    endtask

    // n full output periods of half-period div; optionally followed by the done cycle.
    task automatic exp_periods(input int div, input int n, input bit ends);
        int d;
        d = (div == 0) ? 1 : div;
        for (int p = 0; p < n; p++) begin
            for (int c = 0; c < d; c++) sb.push_back({1'b1, (c == 0), 1'b0, 1'b1, 1'b0, 1'b1});
            for (int c = 0; c < d; c++) sb.push_back({1'b0, 1'b0, (c == 0), 1'b1, 1'b0, 1'b1});
        end
        if (ends) sb.push_back(6'b000011);
    endtask

    task automatic cfg_idle(input int div, input int burst);
        cfg_valid = 1'b1;
        cfg_div   = CNT_W'(div);
        cfg_burst = BURST_W'(burst);
        exp_idle(1);
        tick();
        cfg_valid = 1'b0;
    endtask

    initial begin
        n_cmp = 0; n_bad = 0; n_rise = 0; n_done = 0; cyc = 0;
        rst_n = 1'b0; cfg_valid = 1'b0; cfg_div = '0; cfg_burst = '0;
        start = 1'b0; stop = 1'b0;

        cur_tag = "reset";
        #3;
        chk("reset_outputs", 32'(obs_vec()), 32'(6'b000001));
        @(negedge clk_in);
        rst_n = 1'b1;
        exp_idle(2);
        drain();

        // Reset ratio: divide-by-2, continuous, stop in a high phase.
        cur_tag = "default";
        start = 1'b1;
        exp_periods(1, 4, 1'b1);
        tick();
        start = 1'b0;
        repeat (6) tick();
        stop = 1'b1;
        tick();
        stop = 1'b0;
        drain();
        exp_idle(2);
        drain();

        // Burst of 4 periods at 3/3.
        cur_tag = "burst";
        cfg_idle(3, 4);
        n_rise = 0; n_done = 0;
        start = 1'b1;
        exp_periods(3, 4, 1'b1);
        tick();
        start = 1'b0;
        drain();
        exp_idle(2);
        drain();
        chk("burst_rise_count", 32'(n_rise), 32'd4);
        chk("burst_done_count", 32'(n_done), 32'd1);

        // Ratio change while running: 5/5 period, then 2/2.
        cur_tag = "onthefly";
        cfg_idle(5, 0);
        start = 1'b1;
        for (int c = 0; c < 10; c++)
            sb.push_back({(c < 5), (c == 0), (c == 5), 1'b1, 1'b0, (c < 2)});
        tick();
        start = 1'b0;
        tick();
        cfg_valid = 1'b1;
        cfg_div   = 8'd2;
        cfg_burst = 16'd0;
        tick();
        cfg_valid = 1'b0;
        drain();
        exp_periods(2, 1, 1'b1);
        tick();
        stop = 1'b1;
        tick();
        stop = 1'b0;
        drain();

        // start+stop together in IDLE does nothing.
        cur_tag = "collision";
        start = 1'b1;
        stop  = 1'b1;
        exp_idle(3);
        tick();
        start = 1'b0;
        stop  = 1'b0;
        drain();

        // stop in a low phase ends at the end of that low phase.
        cur_tag = "stop_low";
        cfg_idle(3, 0);
        start = 1'b1;
        exp_periods(3, 1, 1'b1);
        tick();
        start = 1'b0;
        repeat (3) tick();
        stop = 1'b1;
        tick();
        stop = 1'b0;
        drain();

        // cfg_div = 0 behaves as divide-by-2; burst of 2.
        cur_tag = "zero_div";
        cfg_idle(0, 2);
        start = 1'b1;
        exp_periods(0, 2, 1'b1);
        tick();
        start = 1'b0;
        drain();
        exp_idle(1);
        drain();

        // Asynchronous reset while clk_out is high with a shadow pending.
        cur_tag = "async_rst";
        cfg_idle(4, 0);
        start = 1'b1;
        sb.push_back(6'b110101);
        sb.push_back(6'b100100);
        sb.push_back(6'b100100);
        tick();
        start = 1'b0;
        cfg_valid = 1'b1;
        cfg_div   = 8'd7;
        tick();
        cfg_valid = 1'b0;
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_outputs", 32'(obs_vec()), 32'(6'b000001));
        @(negedge clk_in);
        rst_n = 1'b1;
        cur_tag = "after_rst";
        start = 1'b1;
        exp_periods(1, 2, 1'b1);
        tick();
        start = 1'b0;
        repeat (2) tick();
        stop = 1'b1;
        tick();
        stop = 1'b0;
        drain();
        exp_idle(2);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, observed running expected finished");
        $fatal(1, "watchdog");
    end

endmodule
